// File: rtl/serial_adder_checker_pkg.sv
// Shared types and helpers for the digit-serial adder checker.
package serial_adder_checker_pkg;

  // Control states of the serial adder sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Digit counter width: clog2(n), never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_checker_if.sv
// Request/result bundle of the serial adder checker.
//
// Handshake: the master raises start with a, b, cin and inj stable; the
// request is taken on the rising edge where start=1 and busy=0, otherwise it
// is dropped (never queued). busy stays high from the cycle after acceptance
// through the done cycle. done is a one-cycle valid with no backpressure;
// sum, cout and err hold from done until the next done.
interface serial_adder_checker_if
  import serial_adder_checker_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 8
) ();

  logic                start;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                cin;
  logic                inj;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    sum;
  logic                cout;
  logic                err;
  logic [ERRCNT_W-1:0] err_count;
  state_t              state_dbg;

  modport master (
    output start, a, b, cin, inj,
    input  busy, done, sum, cout, err, err_count, state_dbg
  );

  modport slave (
    input  start, a, b, cin, inj,
    output busy, done, sum, cout, err, err_count, state_dbg
  );

endinterface

// File: rtl/serial_adder_checker_digit_adder.sv
// DIGIT-bit combinational ripple-carry slice used once per serial step.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic c;

  // Ripple the carry from the least significant bit upward.
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder_checker.sv
// Digit-serial adder that checks its own result against a one-shot reference
// sum and keeps a saturating count of mismatches.
module serial_adder_checker
  import serial_adder_checker_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGIT    = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_adder_checker_if.slave   bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);

  state_t state, state_n;

  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    a_sr;
  logic [WIDTH-1:0]    b_sr;
  logic [WIDTH-1:0]    res_sr;
  logic [WIDTH-1:0]    res_next;
  logic [WIDTH-1:0]    inj_mask;
  logic [WIDTH:0]      ref_q;
  logic                carry;
  logic                inj_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                err_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic [DIGIT-1:0]    dig_s;
  logic                dig_c;
  logic                accept;
  logic                last;
  logic                err_now;

  // Lowest digit of the operand shift registers feeds the single slice.
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_c)
  );

  // Result register after this step: new digit enters at the top, so after
  // N steps digit 0 sits at the bottom. Injection flips bit 0 of the serial
  // result only; the reference is never touched.
  always_comb begin
    last     = (cnt == CW'(N - 1));
    res_next = (res_sr >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    inj_mask = {{(WIDTH-1){1'b0}}, inj_q};
    err_now  = ({dig_c, res_next ^ inj_mask} != ref_q);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = CHECK;
      end
      CHECK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; reset wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand capture, serial stepping, and result/error capture. The final
  // step writes sum/cout/err and the error count so they are already valid
  // during the CHECK (done) cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      ref_q     <= '0;
      carry     <= 1'b0;
      inj_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      carry  <= bus.cin;
      inj_q  <= bus.inj;
      ref_q  <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      carry  <= dig_c;
      res_sr <= res_next;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum_q  <= res_next ^ inj_mask;
        cout_q <= dig_c;
        err_q  <= err_now;
        if (err_now && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == CHECK);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_serial_adder_checker.sv
// Bench for serial_adder_checker: DIGIT=1 and DIGIT=4 instances side by side,
// directed vectors with hand-computed results, queue scoreboard per instance.
module tb_serial_adder_checker;
  import serial_adder_checker_pkg::*;

  localparam int N0 = 8;
  localparam int N1 = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  // expected entry: {done_cycle[15:0], err_count[7:0], err, cout, sum[7:0]}
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  serial_adder_checker_if #(.WIDTH(8), .ERRCNT_W(8)) bus0 ();
  serial_adder_checker_if #(.WIDTH(8), .ERRCNT_W(2)) bus1 ();

  serial_adder_checker #(.WIDTH(8), .DIGIT(1), .ERRCNT_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  serial_adder_checker #(.WIDTH(8), .DIGIT(4), .ERRCNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // scoreboard monitors: pop and compare whenever done is seen
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && bus0.done) begin
      chk("d0_done_expected", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        chk("d0_done_cycle", 32'(cyc[15:0]), 32'(e[33:18]));
        chk("d0_sum",        32'(bus0.sum),  32'(e[7:0]));
        chk("d0_cout",       32'(bus0.cout), 32'(e[8]));
        chk("d0_err",        32'(bus0.err),  32'(e[9]));
        chk("d0_err_count",  32'(bus0.err_count), 32'(e[17:10]));
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && bus1.done) begin
      chk("d1_done_expected", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        chk("d1_done_cycle", 32'(cyc[15:0]), 32'(e[33:18]));
        chk("d1_sum",        32'(bus1.sum),  32'(e[7:0]));
        chk("d1_cout",       32'(bus1.cout), 32'(e[8]));
        chk("d1_err",        32'(bus1.err),  32'(e[9]));
        chk("d1_err_count",  32'(bus1.err_count), 32'(e[17:10]));
      end
    end
  end

  // driver tasks (entered and left at a falling edge)
  task automatic wait_idle(input int u);
    int k;
    k = 0;
    while (((u == 0) ? bus0.busy : bus1.busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) chk("idle_timeout", 32'((u == 0) ? bus0.busy : bus1.busy), 32'd0);
  endtask

  task automatic drive(input int u, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic inj);
    if (u == 0) begin
      bus0.start = st; bus0.a = a; bus0.b = b; bus0.cin = ci; bus0.inj = inj;
    end else begin
      bus1.start = st; bus1.a = a; bus1.b = b; bus1.cin = ci; bus1.inj = inj;
    end
  endtask

  task automatic push(input int u, input logic [7:0] es, input logic ec,
                      input logic ee, input logic [7:0] eec);
    logic [15:0] dc;
    dc = 16'(cyc + 1 + ((u == 0) ? N0 : N1));
    if (u == 0) exp_q0.push_back({dc, eec, ee, ec, es});
    else        exp_q1.push_back({dc, eec, ee, ec, es});
  endtask

  task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic inj, input logic [7:0] es,
                       input logic ec, input logic ee, input logic [7:0] eec);
    wait_idle(u);
    drive(u, 1'b1, a, b, ci, inj);
    push(u, es, ec, ee, eec);
    @(negedge clk);
    drive(u, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_busy0",  32'(bus0.busy), 32'd0);
    chk("rst_done0",  32'(bus0.done), 32'd0);
    chk("rst_sum0",   32'(bus0.sum),  32'd0);
    chk("rst_cout0",  32'(bus0.cout), 32'd0);
    chk("rst_err0",   32'(bus0.err),  32'd0);
    chk("rst_ecnt0",  32'(bus0.err_count), 32'd0);
    chk("rst_state0", 32'(bus0.state_dbg), 32'(IDLE));
    chk("rst_busy1",  32'(bus1.busy), 32'd0);
    chk("rst_ecnt1",  32'(bus1.err_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIGIT=1 directed vectors
    issue(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'd0);
    issue(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'd0);
    issue(0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0);
    issue(0, 8'h55, 8'hAA, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 8'd1);
    issue(0, 8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 8'd1);

    // start held high through a whole operation: only the first and the one
    // after the done cycle are taken
    wait_idle(0);
    drive(0, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    push(0, 8'h30, 1'b0, 1'b0, 8'd1);
    @(negedge clk);
    drive(0, 1'b1, 8'h33, 8'h33, 1'b0, 1'b1);
    repeat (N0 + 1) @(negedge clk);
    chk("busy_after_done", 32'(bus0.busy), 32'd0);
    drive(0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    push(0, 8'h00, 1'b1, 1'b0, 8'd1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // reset in the middle of RUN: aborted without done, counter cleared
    wait_idle(0);
    drive(0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrun_busy", 32'(bus0.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  32'(bus0.busy), 32'd0);
    chk("abort_done",  32'(bus0.done), 32'd0);
    chk("abort_ecnt",  32'(bus0.err_count), 32'd0);
    chk("abort_state", 32'(bus0.state_dbg), 32'(IDLE));
    chk("abort_sum",   32'(bus0.sum), 32'd0);
    repeat (N0 + 3) @(negedge clk);
    chk("abort_still_idle", 32'(bus0.busy), 32'd0);

    issue(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 8'd0);
    issue(0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd1);

    // DIGIT=4, 2-bit saturating counter
    issue(1, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'd0);
    issue(1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd1);
    issue(1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd2);
    issue(1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd3);
    issue(1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd3);
    issue(1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd3);
    issue(1, 8'hF8, 8'h08, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'd3);

    // drain the scoreboard
    k = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_checker.md
# serial_adder_checker

Parametrised digit-serial adder with a built-in self-check. Each accepted operation adds A+B+Cin DIGIT bits per cycle, compares the serial result against a single-cycle reference sum, and flags and counts mismatches. It sits in the adder-verification path as the sequential, self-checking successor to the fixed 8-bit combinational adder-plus-comparator pairing. A fault-injection input lets benches prove the checker fires.

## Interface
- WIDTH, 8, operand width in bits; WIDTH ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- ERRCNT_W, 8, width of the saturating mismatch counter.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; honoured only while busy=0.
- a  in  WIDTH  operand A, sampled on the accepted start.
- b  in  WIDTH  operand B, sampled on the accepted start.
- cin  in  1  carry-in, sampled on the accepted start.
- inj  in  1  fault inject, sampled on the accepted start; inverts bit 0 of the serial sum.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse; sum, cout and err are valid from this cycle.
- sum  out  WIDTH  serial-path sum; holds its value until the next done.
- cout  out  1  serial-path carry-out; holds its value until the next done.
- err  out  1  1 if the serial {cout,sum} differs from the reference; holds its value until the next done.
- err_count  out  ERRCNT_W  total mismatches since reset, saturating.

## Operation
- N = WIDTH/DIGIT.
- States:
  - IDLE: start=1 latches a, b, cin and inj into the operand registers. It also latches ref = a+b+cin as a WIDTH+1-bit value, then moves to RUN with the digit counter at 0.
  - RUN: adds digit k, bits [k*DIGIT +: DIGIT], of A and B with the carry register. The carry register starts from cin. The result digit goes into the result shift register, LSB digit first, and the new carry is stored. The counter increments; after the digit N-1 cycle the FSM moves to CHECK.
  - CHECK: drives sum, cout, err and done=1. err = ({carry, result ^ inj} != ref). If err=1 and err_count is below all-ones, err_count increments. Next state is IDLE.
- Arithmetic is unsigned, modulo 2^WIDTH. The final carry goes to cout.
- start while busy=1 is ignored and not queued. start in the same cycle as done is also ignored, because busy=1 in CHECK.
- inj affects only the serial path, never ref.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, err=0, err_count=0, FSM=IDLE, counter=0.
- start accepted at edge t → busy=1 from t+1 → done=1 during cycle t+N+1 → busy=0 at t+N+2.
- Latency N+1 cycles; maximum throughput is one operation per N+2 cycles. A new start is accepted in the first cycle after done.
- rst=1 in any state, including mid-RUN, returns to IDLE on the next edge. The operation is aborted with no done pulse, and all outputs take their reset values (err_count cleared).
- rst and start asserted together: reset wins.

## Structure
- Shared package holds the state enum (IDLE, RUN, CHECK) and a function computing the counter width, clog2(N) with a minimum of 1.
- One sub-module: digit_adder. It is a DIGIT-bit ripple-carry slice (a, b, cin → s, cout), purely combinational, instanced once in RUN.
- Top level holds the FSM, the digit counter, the operand/result shift registers, the reference register and the error counter.

## Test plan
- Reset: hold rst for 2 cycles → all outputs 0, busy=0. Assert rst mid-RUN → no done pulse, FSM returns to IDLE, err_count=0.
- WIDTH=8, DIGIT=1: a=0x01, b=0x01, cin=0, start at t → done at t+9 with sum=0x02, cout=0, err=0.
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, err=0. a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, err=0.
- a=0x55, b=0xAA, cin=1, inj=1 → sum=0x01, cout=1, err=1, err_count=1. Next operation with inj=0 → err=0, err_count stays 1.
- start pulsed every cycle while busy → only one done per N+2 cycles. start in the done cycle is ignored; start one cycle later is accepted.
- WIDTH=8, DIGIT=4, ERRCNT_W=2: 0x0F+0x01+0 → done at t+3, sum=0x10. Five operations with inj=1 → err_count reads 1, 2, 3, 3, 3.
